interrupt_dispatcher: RTL

- Responder end of the interrupt path carried through the pipeline registers.
- Synchronises three external IRQ lines and latches them as pending, arbitrates by priority, and waits for a clean commit point at WB.
- Then captures EPC, flushes every stage register through active-low clr, and redirects the PC to the handler vector.
- Unwinds one nesting level on a committed ERET; sources the inting/ints values that enter the ID_EX register.

---
 rtl/interrupt_dispatcher_pkg.sv | 36 +++
 rtl/interrupt_dispatcher_irq_sync_edge.sv | 29 ++
 rtl/interrupt_dispatcher.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/interrupt_dispatcher_pkg.sv
// Shared constants, FSM encoding and helpers for the interrupt dispatcher.
// Latency: none (declarations only).
// Backpressure: not applicable.
package interrupt_dispatcher_pkg;

    localparam int INT_LINES  = 3;
    localparam int STATUS_W   = INT_LINES + 1;
    localparam int ST_IE      = 0;
    localparam int ST_MASK_LO = 1;

    localparam logic [9:0] VEC_BASE_DEF   = 10'h080;
    localparam logic [9:0] VEC_STRIDE_DEF = 10'h010;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_DISPATCH = 2'd2,
        S_UNWIND   = 2'd3
    } state_t;

    // Strict priority means the most recently entered handler is always the highest set bit.
    function automatic logic [INT_LINES-1:0] clear_highest(input logic [INT_LINES-1:0] v);
        logic [INT_LINES-1:0] r;
        logic                 found;
        r     = v;
        found = 1'b0;
        for (int i = INT_LINES - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                r[i]  = 1'b0;
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/interrupt_dispatcher_irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous IRQ line plus a one-cycle rising-edge pulse.
// Latency: pulse is high during the cycle after the second sync edge (pending lands on the third).
// Backpressure: none; free-running regardless of pipeline enable.
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_async,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= irq_async;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/interrupt_dispatcher.sv
// Interrupt responder: latch IRQs, arbitrate by priority, flush and redirect at a WB commit point, unwind on ERET.
// Latency: irq_in to pending 3 clk; eligible request to DISPATCH after IDLE->REQ plus first commit_valid.
// Backpressure: en=0 freezes FSM, status and EPC stack; flush_n/redirect forced inactive meanwhile.
module interrupt_dispatcher
    import interrupt_dispatcher_pkg::*;
#(
    parameter int                     IM_ADDR_BIT = 10,
    parameter logic [IM_ADDR_BIT-1:0] VEC_BASE    = IM_ADDR_BIT'(VEC_BASE_DEF),
    parameter logic [IM_ADDR_BIT-1:0] VEC_STRIDE  = IM_ADDR_BIT'(VEC_STRIDE_DEF)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [INT_LINES-1:0]   irq_in,
    input  logic                   commit_valid,
    input  logic [IM_ADDR_BIT-1:0] commit_pc_4,
    input  logic                   eret_commit,
    input  logic                   halt_commit,
    input  logic [STATUS_W-1:0]    cp0_w_en,
    input  logic [STATUS_W-1:0]    cp0_w_data,
    output logic                   flush_n,
    output logic                   redirect,
    output logic [IM_ADDR_BIT-1:0] redirect_pc,
    output logic                   inting,
    output logic [INT_LINES-1:0]   ints,
    output logic [INT_LINES-1:0]   pending,
    output logic [STATUS_W-1:0]    status
);

    logic [INT_LINES-1:0] rise;
    logic [INT_LINES-1:0] pending_q;
    logic [INT_LINES-1:0] in_service_q;
    logic [INT_LINES-1:0] eligible;
    logic [INT_LINES-1:0] pend_clr;
    logic [STATUS_W-1:0]  status_q;
    logic                 halted_q;
    logic                 any_eligible;
    logic [1:0]           pick;

    state_t state_q;
    state_t state_d;
    logic [1:0] sel_q;
    logic [1:0] sel_d;
    logic       capture;
    logic       do_push;
    logic       do_pop;

    logic [IM_ADDR_BIT-1:0] epc_q;
    logic [IM_ADDR_BIT-1:0] redirect_pc_q;
    logic [IM_ADDR_BIT-1:0] vec;
    logic [IM_ADDR_BIT-1:0] stack_top;
    logic [INT_LINES-1:0][IM_ADDR_BIT-1:0] stack_q;
    logic [1:0] depth_q;
    logic [1:0] top_idx;
    logic       stack_empty;

    for (genvar g = 0; g < INT_LINES; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk       (clk),
            .rst_n     (rst_n),
            .irq_async (irq_in[g]),
            .rise      (rise[g])
        );
    end

    // A line may only preempt handlers strictly below it.
    always_comb begin
        eligible     = '0;
        pick         = '0;
        for (int i = 0; i < INT_LINES; i++) begin
            eligible[i] = pending_q[i] & status_q[ST_MASK_LO + i] & status_q[ST_IE]
                        & ~halted_q & ~|(in_service_q >> i);
        end
        for (int i = 0; i < INT_LINES; i++) begin
            if (eligible[i]) pick = 2'(i);
        end
        any_eligible = |eligible;
    end

    assign stack_empty = (depth_q == 2'd0);
    assign top_idx     = depth_q - 2'd1;
    assign stack_top   = stack_q[top_idx];
    assign vec         = VEC_BASE + IM_ADDR_BIT'(sel_q) * VEC_STRIDE;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        capture = 1'b0;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (eret_commit && !stack_empty) begin
                        state_d = S_UNWIND;
                    end else if (any_eligible) begin
                        state_d = S_REQ;
                        sel_d   = pick;
                    end
                end
                S_REQ: begin
                    if (eret_commit && !stack_empty) begin
                        state_d = S_UNWIND;
                    end else if (commit_valid) begin
                        state_d = S_DISPATCH;
                        capture = 1'b1;
                    end
                end
                S_DISPATCH: begin
                    state_d = S_IDLE;
                    do_push = 1'b1;
                end
                S_UNWIND: begin
                    state_d = S_IDLE;
                    do_pop  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pend_clr = '0;
        if (do_push) pend_clr[sel_q] = 1'b1;
    end

    assign flush_n     = ~(do_push | do_pop);
    assign redirect    = do_push | do_pop;
    assign redirect_pc = do_push ? vec : (do_pop ? stack_top : redirect_pc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sel_q         <= '0;
            epc_q         <= '0;
            redirect_pc_q <= '0;
            stack_q       <= '0;
            depth_q       <= '0;
            in_service_q  <= '0;
            status_q      <= '1;
            halted_q      <= 1'b0;
            pending_q     <= '0;
        end else begin
            // Set after clear: a fresh edge on the line being dispatched survives.
            pending_q     <= (pending_q & ~pend_clr) | rise;
            redirect_pc_q <= redirect_pc;
            if (en) begin
                state_q  <= state_d;
                sel_q    <= sel_d;
                status_q <= (status_q & ~cp0_w_en) | (cp0_w_data & cp0_w_en);
                if (halt_commit) halted_q <= 1'b1;
                if (capture) epc_q <= commit_pc_4;
                if (do_push) begin
                    stack_q[depth_q]    <= epc_q;
                    depth_q             <= depth_q + 2'd1;
                    in_service_q[sel_q] <= 1'b1;
                end
                if (do_pop) begin
                    depth_q      <= top_idx;
                    in_service_q <= clear_highest(in_service_q);
                end
            end
        end
    end

    assign inting  = |in_service_q;
    assign ints    = in_service_q;
    assign pending = pending_q;
    assign status  = status_q;

endmodule
